punc_datapath: RTL and testbench
================================

// Module: punc_datapath
// PURPOSE
//  Datapath for the PUnC LC3 processor, directly downstream of the control FSM.
//  Takes the 5-bit state code and executes that state's register-transfer action.
//  Holds PC, IR, NZP, an 8x16 register file and a 16-bit temp register; drives memory.
//  Returns IR to the control FSM as 'instruction' to close the fetch/decode loop.
// PARAMETERS
//  PC_RESET   16'h0000  PC value loaded on reset
//  NZP_RESET  3'b010    condition codes loaded on reset (Z)
// PORTS
//  clk          in   1   clock
//  rst          in   1   reset: synchronous, active-high
//  state        in   5   FSM state code: FETCH=0 DECODE=1 ADD1=2 ADD2=3 AND1=4 AND2=5 BR=6
//                        JMP=7 JSR1=8 JSR2=9 JSRR1=10 JSRR2=11 LD=12 LDI1=13 LDI2=14 LDR=15
//                        LEA=16 NOT=17 RET=18 ST=19 STI1=20 STI2=21 STR=22 HALT=23
//  instruction  out  16  IR contents, to control FSM
//  mem_addr     out  16  memory address (combinational from state/regs)
//  mem_rdata    in   16  memory read data, combinational from mem_addr in the same cycle
//  mem_wdata    out  16  memory write data
//  mem_we       out  1   memory write enable; memory writes on the clk edge
//  pc           out  16  current PC (debug)
//  nzp          out  3   current condition codes {N,Z,P}
//  halted       out  1   high while state==HALT
//  dbg_sel      in   3   register-file debug read select
//  dbg_data     out  16  R[dbg_sel], combinational
// BEHAVIOUR
//  Reset (rst=1 at edge)
//   - PC<=PC_RESET, IR<=0, NZP<=NZP_RESET, R0..R7<=0, temp<=0.
//   - mem_we forced 0 during the rst cycle. rst overrides every write in any state.
//  Fields and immediates
//   - DR/SR=IR[11:9], SR1/BaseR=IR[8:6], SR2=IR[2:0].
//   - imm5, off6, off9 and off11 are sign-extended to 16 bits.
//  Arithmetic
//   - All arithmetic is 16-bit modulo 2^16; wrap silently, no flags other than NZP.
//  NZP
//   - Written only by ADD1/2, AND1/2, NOT, LD, LDI2 and LDR. LEA does not write NZP.
//   - Value computed from the data written to DR: N=bit15, Z=(==0), P=otherwise.
//   - Exactly one NZP bit is set after any update.
//  PC as operand
//   - Every PC-relative calculation uses the already-incremented PC (PC+1 written in FETCH).
//  Per-state actions; each state is one cycle and all writes commit at the end of that cycle:
//   - FETCH: mem_addr=PC; IR<=mem_rdata; PC<=PC+1.
//   - DECODE: no writes.
//   - ADD1: DR<=SR1+SR2.  ADD2: DR<=SR1+imm5.  AND1/AND2: bitwise AND, same operands.
//   - NOT: DR<=~SR1.
//   - BR: if (IR[11:9]&NZP)!=0 then PC<=PC+off9. IR[11:9]==0 never branches.
//   - JMP / RET: PC<=R[BaseR]. RET is identical to JMP.
//   - JSR1: R7<=PC.  JSR2: PC<=PC+off11.
//   - JSRR1: temp<=R[BaseR] and R7<=PC in the same edge.
//     temp captures the pre-write R[BaseR], so BaseR=R7 is safe.
//   - JSRR2: PC<=temp.
//   - LD: mem_addr=PC+off9; DR<=mem_rdata.
//   - LDI1: mem_addr=PC+off9; temp<=mem_rdata.  LDI2: mem_addr=temp; DR<=mem_rdata.
//   - LDR: mem_addr=R[BaseR]+off6; DR<=mem_rdata.
//   - LEA: DR<=PC+off9.
//   - ST: mem_addr=PC+off9; mem_wdata=R[SR]; mem_we=1.
//   - STI1: mem_addr=PC+off9; temp<=mem_rdata.  STI2: mem_addr=temp, write R[SR].
//   - STR: mem_addr=R[BaseR]+off6, write R[SR].
//   - HALT: no writes; halted=1; PC and all registers hold.
//   - Codes 24-31: no writes, mem_we=0.
//  Defaults
//   - mem_we=0 and mem_wdata=0 outside ST/STI2/STR.
//   - mem_addr=PC in states without a memory access.
//  Register file
//   - Register reads are combinational, so a read in the same cycle as a write to that register returns the old value.
//   - One register-file write port; at most one write per cycle (JSRR1 writes R7 and temp, a separate register).
// TESTING
//  1 Reset with PC_RESET=16'h3000 -> pc=3000, instruction=0, nzp=010, all regs 0, mem_we=0.
//  2 mem[3000]=16'h1261 (ADD R1,R1,#1); states FETCH,DECODE,ADD2 -> R1=0001, nzp=001, pc=3001.
//  3 R2=16'h7FFF; ADD2 with imm5=+1 -> DR=8000, nzp=100 (wrap); then AND2 imm5=0 -> DR=0, nzp=010.
//  4 JSRR with BaseR=R7, R7=16'h4000, PC=3005 -> after JSRR2 pc=4000, R7=3005.
//  5 STI at PC=3001, off9=+2, mem[3003]=16'h5000, R3=16'hBEEF -> STI2: mem_we=1, addr=5000, wdata=BEEF.
//  6 BR with IR[11:9]=000 and BR n with nzp=010 -> pc unchanged; rst asserted during LDI2 -> no DR write, pc=PC_RESET.

Source files
------------

// File: rtl/punc_datapath.sv
// PUnC LC3 datapath: executes the register-transfer action selected by the
// control FSM's state code; holds PC, IR, NZP, R0-R7 and a temp register.
module punc_datapath #(
    parameter logic [15:0] PC_RESET  = 16'h0000,
    parameter logic [2:0]  NZP_RESET = 3'b010
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  state,
    output logic [15:0] instruction,
    output logic [15:0] mem_addr,
    input  logic [15:0] mem_rdata,
    output logic [15:0] mem_wdata,
    output logic        mem_we,
    output logic [15:0] pc,
    output logic [2:0]  nzp,
    output logic        halted,
    input  logic [2:0]  dbg_sel,
    output logic [15:0] dbg_data
);

    typedef enum logic [4:0] {
        S_FETCH = 5'd0,  S_DECODE = 5'd1,  S_ADD1  = 5'd2,  S_ADD2  = 5'd3,
        S_AND1  = 5'd4,  S_AND2   = 5'd5,  S_BR    = 5'd6,  S_JMP   = 5'd7,
        S_JSR1  = 5'd8,  S_JSR2   = 5'd9,  S_JSRR1 = 5'd10, S_JSRR2 = 5'd11,
        S_LD    = 5'd12, S_LDI1   = 5'd13, S_LDI2  = 5'd14, S_LDR   = 5'd15,
        S_LEA   = 5'd16, S_NOT    = 5'd17, S_RET   = 5'd18, S_ST    = 5'd19,
        S_STI1  = 5'd20, S_STI2   = 5'd21, S_STR   = 5'd22, S_HALT  = 5'd23
    } state_e;

    logic [15:0] pc_q, ir_q, temp_q;
    logic [2:0]  nzp_q;
    logic [15:0] regs [8];

    // Instruction fields and sign-extended immediates.
    logic [2:0]  dr, sr1, sr2;
    logic [15:0] imm5, off6, off9, off11;
    logic [15:0] sr_val, sr1_val, sr2_val, pc_rel, base_rel;

    assign dr    = ir_q[11:9];
    assign sr1   = ir_q[8:6];
    assign sr2   = ir_q[2:0];
    assign imm5  = {{11{ir_q[4]}},  ir_q[4:0]};
    assign off6  = {{10{ir_q[5]}},  ir_q[5:0]};
    assign off9  = {{7{ir_q[8]}},   ir_q[8:0]};
    assign off11 = {{5{ir_q[10]}},  ir_q[10:0]};

    assign sr_val   = regs[dr];
    assign sr1_val  = regs[sr1];
    assign sr2_val  = regs[sr2];
    assign pc_rel   = pc_q + off9;
    assign base_rel = sr1_val + off6;

    function automatic logic [2:0] nzp_of(input logic [15:0] value);
        if (value[15])          return 3'b100;
        else if (value == 16'h0) return 3'b010;
        else                     return 3'b001;
    endfunction

    logic [15:0] pc_next, temp_next, rf_wdata;
    logic [2:0]  rf_waddr;
    logic        ir_we, temp_we, rf_we, nzp_we, mem_we_int;

    // NOTE: every signal gets a default before the case so no state can leave one unassigned and infer a latch.
    always_comb begin
        pc_next    = pc_q;
        ir_we      = 1'b0;
        temp_we    = 1'b0;
        temp_next  = mem_rdata;
        rf_we      = 1'b0;
        rf_waddr   = dr;
        rf_wdata   = 16'h0;
        nzp_we     = 1'b0;
        mem_addr   = pc_q;
        mem_we_int = 1'b0;
        mem_wdata  = 16'h0;
        case (state)
            S_FETCH: begin
                ir_we   = 1'b1;
                pc_next = pc_q + 16'd1;
            end
            S_ADD1:  begin rf_we = 1'b1; nzp_we = 1'b1; rf_wdata = sr1_val + sr2_val; end
            S_ADD2:  begin rf_we = 1'b1; nzp_we = 1'b1; rf_wdata = sr1_val + imm5;    end
            S_AND1:  begin rf_we = 1'b1; nzp_we = 1'b1; rf_wdata = sr1_val & sr2_val; end
            S_AND2:  begin rf_we = 1'b1; nzp_we = 1'b1; rf_wdata = sr1_val & imm5;    end
            S_NOT:   begin rf_we = 1'b1; nzp_we = 1'b1; rf_wdata = ~sr1_val;          end
            S_BR: begin
                if ((ir_q[11:9] & nzp_q) != 3'b000) pc_next = pc_rel;
            end
            S_JMP, S_RET: pc_next = sr1_val;
            S_JSR1: begin
                rf_we    = 1'b1;
                rf_waddr = 3'd7;
                rf_wdata = pc_q;
            end
            S_JSR2: pc_next = pc_q + off11;
            S_JSRR1: begin
                // temp takes the pre-edge R[BaseR], so BaseR == R7 still jumps correctly.
                temp_we   = 1'b1;
                temp_next = sr1_val;
                rf_we     = 1'b1;
                rf_waddr  = 3'd7;
                rf_wdata  = pc_q;
            end
            S_JSRR2: pc_next = temp_q;
            S_LD: begin
                mem_addr = pc_rel;
                rf_we    = 1'b1;
                nzp_we   = 1'b1;
                rf_wdata = mem_rdata;
            end
            S_LDI1, S_STI1: begin
                mem_addr = pc_rel;
                temp_we  = 1'b1;
            end
            S_LDI2: begin
                mem_addr = temp_q;
                rf_we    = 1'b1;
                nzp_we   = 1'b1;
                rf_wdata = mem_rdata;
            end
            S_LDR: begin
                mem_addr = base_rel;
                rf_we    = 1'b1;
                nzp_we   = 1'b1;
                rf_wdata = mem_rdata;
            end
            S_LEA: begin
                rf_we    = 1'b1;
                rf_wdata = pc_rel;
            end
            S_ST: begin
                mem_addr   = pc_rel;
                mem_we_int = 1'b1;
                mem_wdata  = sr_val;
            end
            S_STI2: begin
                mem_addr   = temp_q;
                mem_we_int = 1'b1;
                mem_wdata  = sr_val;
            end
            S_STR: begin
                mem_addr   = base_rel;
                mem_we_int = 1'b1;
                mem_wdata  = sr_val;
            end
            S_DECODE, S_HALT: ;
            default: ;
        endcase
    end

    // NOTE: the register file is cleared on reset like the other state, since software may rely on R0-R7 starting at zero.
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q   <= PC_RESET;
            ir_q   <= 16'h0;
            nzp_q  <= NZP_RESET;
            temp_q <= 16'h0;
            for (int i = 0; i < 8; i++) regs[i] <= 16'h0;
        end else begin
            pc_q <= pc_next;
            if (ir_we)   ir_q            <= mem_rdata;
            if (temp_we) temp_q          <= temp_next;
            if (rf_we)   regs[rf_waddr]  <= rf_wdata;
            if (nzp_we)  nzp_q           <= nzp_of(rf_wdata);
        end
    end

    // Memory writes on this same edge, so reset must suppress the strobe directly.
    assign mem_we      = mem_we_int & ~rst;
    assign instruction = ir_q;
    assign pc          = pc_q;
    assign nzp         = nzp_q;
    assign halted      = (state == S_HALT);
    assign dbg_data    = regs[dbg_sel];

endmodule

// File: tb/tb_punc_datapath.sv
// Self-checking bench for punc_datapath: a small LC3 program is stepped through
// state by state from a table of expected bus, PC, NZP and register values.
module tb_punc_datapath;

    localparam logic [4:0] FETCH = 5'd0,  DECODE = 5'd1,  ADD1 = 5'd2,  ADD2 = 5'd3,
                           AND2  = 5'd5,  BR     = 5'd6,  JSR1 = 5'd8,  JSR2 = 5'd9,
                           JSRR1 = 5'd10, JSRR2  = 5'd11, LD   = 5'd12, LDI1 = 5'd13,
                           LDI2  = 5'd14, LDR    = 5'd15, LEA  = 5'd16, NOT  = 5'd17,
                           RET   = 5'd18, ST     = 5'd19, STI1 = 5'd20, STI2 = 5'd21,
                           STR   = 5'd22, HALT   = 5'd23;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  state;
    logic [15:0] instruction, mem_addr, mem_rdata, mem_wdata, pc, dbg_data;
    logic        mem_we, halted;
    logic [2:0]  nzp, dbg_sel;

    logic [15:0] mem [0:65535];

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [4:0]  st;
        logic [15:0] maddr;
        logic        mwe;
        logic [15:0] mwdata;
        logic [15:0] pc;
        logic [2:0]  nzp;
        int          rsel;
        logic [15:0] rval;
    } vec_t;

    vec_t tbl[$];
    vec_t t;

    punc_datapath #(.PC_RESET(16'h3000), .NZP_RESET(3'b010)) dut (
        .clk(clk), .rst(rst), .state(state), .instruction(instruction),
        .mem_addr(mem_addr), .mem_rdata(mem_rdata), .mem_wdata(mem_wdata),
        .mem_we(mem_we), .pc(pc), .nzp(nzp), .halted(halted),
        .dbg_sel(dbg_sel), .dbg_data(dbg_data)
    );

    always #5 clk = ~clk;
    assign mem_rdata = mem[mem_addr];

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic [4:0] st, input logic [15:0] maddr, input logic mwe,
                       input logic [15:0] mwdata, input logic [15:0] epc, input logic [2:0] enzp,
                       input int rsel, input logic [15:0] rval);
        vec_t v;
        v.st = st; v.maddr = maddr; v.mwe = mwe; v.mwdata = mwdata;
        v.pc = epc; v.nzp = enzp; v.rsel = rsel; v.rval = rval;
        tbl.push_back(v);
    endtask

    task automatic check_regs_zero(input string tag);
        for (int r = 0; r < 8; r++) begin
            dbg_sel = 3'(r);
            #1;
            check($sformatf("%s R%0d", tag, r), dbg_data, 16'h0000);
        end
    endtask

    initial begin
        rst = 1'b1; state = ST; dbg_sel = 3'd0;
        for (int a = 0; a < 65536; a++) mem[a] = 16'h0000;
        mem[16'h3000] = 16'h1261; mem[16'h3001] = 16'h241E; mem[16'h3002] = 16'h14A1;
        mem[16'h3003] = 16'h58A0; mem[16'h3004] = 16'h1A42; mem[16'h3005] = 16'h2E1B;
        mem[16'h3006] = 16'h41C0; mem[16'h3020] = 16'h7FFF; mem[16'h3021] = 16'h4000;
        mem[16'h4000] = 16'h9D7F; mem[16'h4001] = 16'hB403; mem[16'h4002] = 16'hA602;
        mem[16'h4003] = 16'h0005; mem[16'h4004] = 16'h0803; mem[16'h4005] = 16'h5000;
        mem[16'h4008] = 16'h5020; mem[16'h4009] = 16'h0805; mem[16'h400A] = 16'h0405;
        mem[16'h4010] = 16'hE3F0; mem[16'h4011] = 16'h6844; mem[16'h4012] = 16'h7D3F;
        mem[16'h4013] = 16'h4820; mem[16'h4014] = 16'hF025; mem[16'h4034] = 16'h6B3F;
        mem[16'h4035] = 16'hC1C0;
        fork
            forever @(posedge clk) if (mem_we) mem[mem_addr] <= mem_wdata;
        join_none

        //   state  mem_addr  we  wdata    pc      nzp    reg  value
        add(FETCH,  16'h3000, 0, 16'h0, 16'h3001, 3'b010, -1, 16'h0);
        add(DECODE, 16'h3001, 0, 16'h0, 16'h3001, 3'b010, -1, 16'h0);
        add(ADD2,   16'h3001, 0, 16'h0, 16'h3001, 3'b001,  1, 16'h0001);
        add(FETCH,  16'h3001, 0, 16'h0, 16'h3002, 3'b001, -1, 16'h0);
        add(DECODE, 16'h3002, 0, 16'h0, 16'h3002, 3'b001, -1, 16'h0);
        add(LD,     16'h3020, 0, 16'h0, 16'h3002, 3'b001,  2, 16'h7FFF);
        add(FETCH,  16'h3002, 0, 16'h0, 16'h3003, 3'b001, -1, 16'h0);
        add(DECODE, 16'h3003, 0, 16'h0, 16'h3003, 3'b001, -1, 16'h0);
        add(ADD2,   16'h3003, 0, 16'h0, 16'h3003, 3'b100,  2, 16'h8000);
        add(FETCH,  16'h3003, 0, 16'h0, 16'h3004, 3'b100, -1, 16'h0);
        add(DECODE, 16'h3004, 0, 16'h0, 16'h3004, 3'b100, -1, 16'h0);
        add(AND2,   16'h3004, 0, 16'h0, 16'h3004, 3'b010,  4, 16'h0000);
        add(FETCH,  16'h3004, 0, 16'h0, 16'h3005, 3'b010, -1, 16'h0);
        add(DECODE, 16'h3005, 0, 16'h0, 16'h3005, 3'b010, -1, 16'h0);
        add(ADD1,   16'h3005, 0, 16'h0, 16'h3005, 3'b100,  5, 16'h8001);
        add(FETCH,  16'h3005, 0, 16'h0, 16'h3006, 3'b100, -1, 16'h0);
        add(DECODE, 16'h3006, 0, 16'h0, 16'h3006, 3'b100, -1, 16'h0);
        add(LD,     16'h3021, 0, 16'h0, 16'h3006, 3'b001,  7, 16'h4000);
        add(FETCH,  16'h3006, 0, 16'h0, 16'h3007, 3'b001, -1, 16'h0);
        add(DECODE, 16'h3007, 0, 16'h0, 16'h3007, 3'b001, -1, 16'h0);
        add(JSRR1,  16'h3007, 0, 16'h0, 16'h3007, 3'b001,  7, 16'h3007);
        add(JSRR2,  16'h3007, 0, 16'h0, 16'h4000, 3'b001,  7, 16'h3007);
        add(FETCH,  16'h4000, 0, 16'h0, 16'h4001, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4001, 0, 16'h0, 16'h4001, 3'b001, -1, 16'h0);
        add(NOT,    16'h4001, 0, 16'h0, 16'h4001, 3'b001,  6, 16'h7FFE);
        add(FETCH,  16'h4001, 0, 16'h0, 16'h4002, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4002, 0, 16'h0, 16'h4002, 3'b001, -1, 16'h0);
        add(STI1,   16'h4005, 0, 16'h0, 16'h4002, 3'b001, -1, 16'h0);
        add(STI2,   16'h5000, 1, 16'h8000, 16'h4002, 3'b001, -1, 16'h0);
        add(FETCH,  16'h4002, 0, 16'h0, 16'h4003, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4003, 0, 16'h0, 16'h4003, 3'b001, -1, 16'h0);
        add(LDI1,   16'h4005, 0, 16'h0, 16'h4003, 3'b001, -1, 16'h0);
        add(LDI2,   16'h5000, 0, 16'h0, 16'h4003, 3'b100,  3, 16'h8000);
        add(FETCH,  16'h4003, 0, 16'h0, 16'h4004, 3'b100, -1, 16'h0);
        add(DECODE, 16'h4004, 0, 16'h0, 16'h4004, 3'b100, -1, 16'h0);
        add(BR,     16'h4004, 0, 16'h0, 16'h4004, 3'b100, -1, 16'h0);
        add(FETCH,  16'h4004, 0, 16'h0, 16'h4005, 3'b100, -1, 16'h0);
        add(DECODE, 16'h4005, 0, 16'h0, 16'h4005, 3'b100, -1, 16'h0);
        add(BR,     16'h4005, 0, 16'h0, 16'h4008, 3'b100, -1, 16'h0);
        add(FETCH,  16'h4008, 0, 16'h0, 16'h4009, 3'b100, -1, 16'h0);
        add(DECODE, 16'h4009, 0, 16'h0, 16'h4009, 3'b100, -1, 16'h0);
        add(AND2,   16'h4009, 0, 16'h0, 16'h4009, 3'b010,  0, 16'h0000);
        add(FETCH,  16'h4009, 0, 16'h0, 16'h400A, 3'b010, -1, 16'h0);
        add(DECODE, 16'h400A, 0, 16'h0, 16'h400A, 3'b010, -1, 16'h0);
        add(BR,     16'h400A, 0, 16'h0, 16'h400A, 3'b010, -1, 16'h0);
        add(FETCH,  16'h400A, 0, 16'h0, 16'h400B, 3'b010, -1, 16'h0);
        add(DECODE, 16'h400B, 0, 16'h0, 16'h400B, 3'b010, -1, 16'h0);
        add(BR,     16'h400B, 0, 16'h0, 16'h4010, 3'b010, -1, 16'h0);
        add(FETCH,  16'h4010, 0, 16'h0, 16'h4011, 3'b010, -1, 16'h0);
        add(DECODE, 16'h4011, 0, 16'h0, 16'h4011, 3'b010, -1, 16'h0);
        add(LEA,    16'h4011, 0, 16'h0, 16'h4011, 3'b010,  1, 16'h4001);
        add(FETCH,  16'h4011, 0, 16'h0, 16'h4012, 3'b010, -1, 16'h0);
        add(DECODE, 16'h4012, 0, 16'h0, 16'h4012, 3'b010, -1, 16'h0);
        add(LDR,    16'h4005, 0, 16'h0, 16'h4012, 3'b001,  4, 16'h5000);
        add(FETCH,  16'h4012, 0, 16'h0, 16'h4013, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4013, 0, 16'h0, 16'h4013, 3'b001, -1, 16'h0);
        add(STR,    16'h4FFF, 1, 16'h7FFE, 16'h4013, 3'b001, -1, 16'h0);
        add(FETCH,  16'h4013, 0, 16'h0, 16'h4014, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4014, 0, 16'h0, 16'h4014, 3'b001, -1, 16'h0);
        add(JSR1,   16'h4014, 0, 16'h0, 16'h4014, 3'b001,  7, 16'h4014);
        add(JSR2,   16'h4014, 0, 16'h0, 16'h4034, 3'b001,  7, 16'h4014);
        add(FETCH,  16'h4034, 0, 16'h0, 16'h4035, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4035, 0, 16'h0, 16'h4035, 3'b001, -1, 16'h0);
        add(LDR,    16'h4FFF, 0, 16'h0, 16'h4035, 3'b001,  5, 16'h7FFE);
        add(FETCH,  16'h4035, 0, 16'h0, 16'h4036, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4036, 0, 16'h0, 16'h4036, 3'b001, -1, 16'h0);
        add(RET,    16'h4036, 0, 16'h0, 16'h4014, 3'b001, -1, 16'h0);
        add(FETCH,  16'h4014, 0, 16'h0, 16'h4015, 3'b001, -1, 16'h0);
        add(DECODE, 16'h4015, 0, 16'h0, 16'h4015, 3'b001, -1, 16'h0);
        add(HALT,   16'h4015, 0, 16'h0, 16'h4015, 3'b001, -1, 16'h0);
        add(HALT,   16'h4015, 0, 16'h0, 16'h4015, 3'b001,  5, 16'h7FFE);
        add(5'd25,  16'h4015, 0, 16'h0, 16'h4015, 3'b001, -1, 16'h0);
        add(5'd31,  16'h4015, 0, 16'h0, 16'h4015, 3'b001,  7, 16'h4014);

        // Reset while presenting a store state: the strobe must stay low.
        repeat (2) @(posedge clk);
        #1;
        check("reset mem_we", 16'(mem_we), 16'h0000);
        check("reset pc", pc, 16'h3000);
        check("reset instruction", instruction, 16'h0000);
        check("reset nzp", 16'(nzp), 16'h0002);
        check_regs_zero("reset");

        for (int i = 0; i < tbl.size(); i++) begin
            t = tbl[i];
            @(negedge clk);
            rst = 1'b0;
            state = t.st;
            #1;
            check($sformatf("step%0d mem_addr", i), mem_addr, t.maddr);
            check($sformatf("step%0d mem_we", i), 16'(mem_we), 16'(t.mwe));
            check($sformatf("step%0d mem_wdata", i), mem_wdata, t.mwdata);
            check($sformatf("step%0d halted", i), 16'(halted), 16'(t.st == HALT));
            @(posedge clk);
            #1;
            check($sformatf("step%0d pc", i), pc, t.pc);
            check($sformatf("step%0d nzp", i), 16'(nzp), 16'(t.nzp));
            if (t.st == FETCH)
                check($sformatf("step%0d instruction", i), instruction, mem[t.maddr]);
            if (t.rsel >= 0) begin
                dbg_sel = t.rsel[2:0];
                #1;
                check($sformatf("step%0d R%0d", i, t.rsel), dbg_data, t.rval);
            end
        end

        check("mem[5000] after STI", mem[16'h5000], 16'h8000);
        check("mem[4FFF] after STR", mem[16'h4FFF], 16'h7FFE);

        // Reset overrides a store and a load in flight.
        @(negedge clk);
        rst = 1'b1;
        state = STR;
        #1;
        check("rst during STR mem_we", 16'(mem_we), 16'h0000);
        @(negedge clk);
        state = LDI2;
        @(posedge clk);
        #1;
        check("rst during LDI2 pc", pc, 16'h3000);
        check("rst during LDI2 nzp", 16'(nzp), 16'h0002);
        check("rst during LDI2 instruction", instruction, 16'h0000);
        check_regs_zero("rst during LDI2");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
